// File: rtl/register_file_mp.sv
// Multi-port register file with same-cycle write forwarding and a busy scoreboard
// that lets the pipeline stall on registers with a pending long-latency write.
module register_file_mp #(
  parameter int N_BITS = 32,
  parameter int N_REGS = 32,
  parameter int ADDR_W = 5,
  parameter int N_READ = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reg_write,
  input  logic [ADDR_W-1:0]        write_register,
  input  logic [N_BITS-1:0]        write_data,
  input  logic [N_READ*ADDR_W-1:0] read_register,
  output logic [N_READ*N_BITS-1:0] read_data,
  input  logic                     reserve_en,
  input  logic [ADDR_W-1:0]        reserve_register,
  output logic [N_READ-1:0]        read_busy,
  output logic [ADDR_W:0]          busy_count
);

  localparam logic [ADDR_W:0] NREGS_W = (ADDR_W+1)'(N_REGS);

  logic [N_BITS-1:0] regs [1:N_REGS-1];
  logic [N_REGS-1:1] busy;
  logic [N_REGS-1:1] busy_nx;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS_W);
  endfunction

  function automatic logic [N_BITS-1:0] stored_data(input logic [ADDR_W-1:0] a);
    logic [N_BITS-1:0] v;
    v = '0;
    for (int r = 1; r < N_REGS; r++)
      if (a == ADDR_W'(r)) v = regs[r];
    return v;
  endfunction

  function automatic logic stored_busy(input logic [ADDR_W-1:0] a);
    logic b;
    b = 1'b0;
    for (int r = 1; r < N_REGS; r++)
      if (a == ADDR_W'(r)) b = busy[r];
    return b;
  endfunction

  function automatic logic [ADDR_W:0] popcount(input logic [N_REGS-1:1] v);
    logic [ADDR_W:0] cnt;
    cnt = '0;
    for (int r = 1; r < N_REGS; r++)
      cnt = cnt + {{ADDR_W{1'b0}}, v[r]};
    return cnt;
  endfunction

  // Forwarding is gated by reset so the outputs read zero throughout reset.
  function automatic logic [N_BITS-1:0] port_data(input logic [ADDR_W-1:0] a);
    if (!in_range(a)) return '0;
    if (reset && reg_write && (write_register == a)) return write_data;
    return stored_data(a);
  endfunction

  function automatic logic port_busy(input logic [ADDR_W-1:0] a);
    return in_range(a) && stored_busy(a) && !(reg_write && (write_register == a));
  endfunction

  always_comb begin
    read_data = '0;
    read_busy = '0;
    for (int p = 0; p < N_READ; p++) begin
      read_data[p*N_BITS +: N_BITS] = port_data(read_register[p*ADDR_W +: ADDR_W]);
      read_busy[p]                  = port_busy(read_register[p*ADDR_W +: ADDR_W]);
    end
  end

  // Reservation is applied after the retiring write so a same-cycle pair stays busy.
  always_comb begin
    busy_nx = busy;
    for (int r = 1; r < N_REGS; r++) begin
      if (reg_write && (write_register == ADDR_W'(r)))   busy_nx[r] = 1'b0;
      if (reserve_en && (reserve_register == ADDR_W'(r))) busy_nx[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 1; r < N_REGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 1; r < N_REGS; r++)
        if (reg_write && (write_register == ADDR_W'(r))) regs[r] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nx;
      busy_count <= popcount(busy_nx);
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a 32x2-port and a 16x4-port instance share one
// write/reserve stimulus stream and are compared against an array-based model.
module tb_register_file_mp;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        reserve_en;
  logic [4:0]  reserve_register;

  logic [9:0]   rr_a;
  logic [63:0]  rd_a;
  logic [1:0]   rb_a;
  logic [5:0]   bc_a;
  logic [19:0]  rr_b;
  logic [127:0] rd_b;
  logic [3:0]   rb_b;
  logic [5:0]   bc_b;

  int passes = 0;
  int checks = 0;

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  bit          bsy_a [32];
  bit          bsy_b [32];

  register_file_mp #(.N_BITS(32), .N_REGS(32), .ADDR_W(5), .N_READ(2)) dut_a (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_register(write_register),
    .write_data(write_data), .read_register(rr_a), .read_data(rd_a),
    .reserve_en(reserve_en), .reserve_register(reserve_register),
    .read_busy(rb_a), .busy_count(bc_a));

  register_file_mp #(.N_BITS(32), .N_REGS(16), .ADDR_W(5), .N_READ(4)) dut_b (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_register(write_register),
    .write_data(write_data), .read_register(rr_b), .read_data(rd_b),
    .reserve_en(reserve_en), .reserve_register(reserve_register),
    .read_busy(rb_b), .busy_count(bc_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int n_of(bit b);
    return b ? 16 : 32;
  endfunction

  function automatic logic [31:0] m_read(bit b, logic [4:0] addr);
    if (addr == 0 || int'(addr) >= n_of(b)) return 32'h0;
    if (reset && reg_write && write_register == addr) return write_data;
    return b ? mem_b[addr] : mem_a[addr];
  endfunction

  function automatic logic m_busy(bit b, logic [4:0] addr);
    if (addr == 0 || int'(addr) >= n_of(b)) return 1'b0;
    if (reg_write && write_register == addr) return 1'b0;
    return b ? bsy_b[addr] : bsy_a[addr];
  endfunction

  function automatic int m_count(bit b);
    int c = 0;
    for (int i = 0; i < 32; i++) c += b ? int'(bsy_b[i]) : int'(bsy_a[i]);
    return c;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = '0; mem_b[i] = '0; bsy_a[i] = 0; bsy_b[i] = 0;
    end
  endtask

  task automatic m_update();
    for (int b = 0; b < 2; b++) begin
      int n = n_of(b[0]);
      if (reg_write && write_register != 0 && int'(write_register) < n) begin
        if (b == 0) begin mem_a[write_register] = write_data; bsy_a[write_register] = 0; end
        else        begin mem_b[write_register] = write_data; bsy_b[write_register] = 0; end
      end
      if (reserve_en && reserve_register != 0 && int'(reserve_register) < n) begin
        if (b == 0) bsy_a[reserve_register] = 1;
        else        bsy_b[reserve_register] = 1;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_comb();
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("a_data%0d@%0d", p, rr_a[p*5 +: 5]), rd_a[p*32 +: 32], m_read(0, rr_a[p*5 +: 5]));
      chk($sformatf("a_busy%0d@%0d", p, rr_a[p*5 +: 5]), {31'b0, rb_a[p]}, {31'b0, m_busy(0, rr_a[p*5 +: 5])});
    end
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("b_data%0d@%0d", p, rr_b[p*5 +: 5]), rd_b[p*32 +: 32], m_read(1, rr_b[p*5 +: 5]));
      chk($sformatf("b_busy%0d@%0d", p, rr_b[p*5 +: 5]), {31'b0, rb_b[p]}, {31'b0, m_busy(1, rr_b[p*5 +: 5])});
    end
  endtask

  task automatic check_count();
    chk("a_count", {26'b0, bc_a}, 32'(m_count(0)));
    chk("b_count", {26'b0, bc_b}, 32'(m_count(1)));
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    check_comb();
    @(posedge clk);
    if (reset) m_update();
    else m_clear();
    #1;
    check_count();
    @(negedge clk);
  endtask

  task automatic set_in(logic we, logic [4:0] wa, logic [31:0] wd,
                        logic re, logic [4:0] ra, logic [4:0] a0, logic [4:0] a1);
    reg_write = we; write_register = wa; write_data = wd;
    reserve_en = re; reserve_register = ra;
    rr_a = {a1, a0};
    rr_b = {a1, a0, a1, a0};
  endtask

  initial begin
    m_clear();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 5'd5, 5'd31);
    #3;
    check_comb();
    check_count();
    @(negedge clk);
    reset = 1'b1;

    set_in(1, 7, 32'hDEADBEEF, 0, 0, 7, 7);   step();
    set_in(0, 0, 0, 0, 0, 7, 7);              step();
    set_in(1, 0, 32'h1234, 0, 0, 0, 7);       step();
    set_in(0, 0, 0, 0, 0, 0, 0);              step();
    set_in(1, 9, 32'h1, 0, 0, 9, 7);          step();
    set_in(1, 9, 32'hA5A5A5A5, 0, 0, 9, 7);   step();
    set_in(0, 0, 0, 0, 0, 9, 9);              step();
    set_in(0, 0, 0, 1, 3, 0, 3);              step();
    set_in(0, 0, 0, 0, 0, 0, 3);              step();
    set_in(1, 3, 32'h77, 0, 0, 3, 3);         step();
    set_in(0, 0, 0, 1, 4, 4, 3);              step();
    set_in(1, 4, 32'h44, 1, 4, 4, 4);         step();
    set_in(0, 0, 0, 0, 0, 4, 4);              step();
    set_in(1, 20, 32'hCAFEF00D, 1, 20, 20, 20); step();
    set_in(0, 0, 0, 0, 0, 20, 15);            step();
    set_in(1, 15, 32'h5, 1, 16, 15, 16);      step();

    for (int i = 0; i < 300; i++) begin
      reg_write        = 1'($urandom_range(0, 1));
      write_register   = 5'($urandom_range(0, 31));
      write_data       = $urandom;
      reserve_en       = 1'($urandom_range(0, 1));
      reserve_register = 5'($urandom_range(0, 31));
      rr_a             = 10'($urandom);
      rr_b             = 20'($urandom);
      if ($urandom_range(0, 3) == 0) rr_a[4:0] = write_register;
      if ($urandom_range(0, 3) == 0) rr_b[9:5] = reserve_register;
      step();
    end

    set_in(1, 10, 32'h0A0A0A0A, 1, 10, 10, 11); step();
    set_in(1, 11, 32'h0B0B0B0B, 1, 11, 10, 11); step();
    set_in(1, 12, 32'h0C0C0C0C, 1, 12, 12, 11); step();
    set_in(1, 10, 32'hFFFFFFFF, 0, 0, 10, 12);
    #2;
    reset = 1'b0;
    m_clear();
    #1;
    check_comb();
    check_count();
    @(negedge clk);
    step();
    step();
    reset = 1'b1;

    for (int i = 0; i < 60; i++) begin
      reg_write        = 1'($urandom_range(0, 1));
      write_register   = 5'($urandom_range(0, 31));
      write_data       = $urandom;
      reserve_en       = 1'($urandom_range(0, 1));
      reserve_register = 5'($urandom_range(0, 31));
      rr_a             = 10'($urandom);
      rr_b             = 20'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port register file with integrated read muxing.
- Successor to the fixed 32:1 register read mux in the RISC-V datapath.
- Generalised in register count, data width and number of read ports.
- Adds write-through forwarding and a per-register busy scoreboard so the pipelined core can stall on long-latency destinations (loads, multi-cycle ops).

Parameters:
- N_BITS, 32, data width of each register
- N_REGS, 32, number of architectural registers (2..32); register 0 hardwired to zero
- ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= N_REGS
- N_READ, 2, number of independent read ports (1..4)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- reg_write  input  1  write enable for write port
- write_register  input  ADDR_W  write address
- write_data  input  N_BITS  write data
- read_register  input  N_READ*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- read_data  output  N_READ*N_BITS  packed read data; port i at bits [i*N_BITS +: N_BITS]
- reserve_en  input  1  mark reserve_register as pending a future write
- reserve_register  input  ADDR_W  register to reserve
- read_busy  output  N_READ  port i source is pending; consumer must stall
- busy_count  output  ADDR_W+1  number of registers currently marked busy

Behaviour:
- Storage: N_REGS-1 flops of N_BITS (reg 1..N_REGS-1); reg 0 not stored and always reads 0.
- Reset (reset=0, async):
  - All registers clear to 0; all busy bits clear.
  - read_data = 0 on every port; read_busy = 0; busy_count = 0.
  - Forwarding is suppressed while reset is asserted.
- Write: on rising clk with reset=1 and reg_write=1, write_data is stored to write_register.
  - Writes to reg 0 or to any address >= N_REGS are ignored.
- Read: fully combinational, zero latency. Per port i:
  - addr = 0 or addr >= N_REGS -> read_data 0.
  - Else if reg_write=1, write_register == addr and reset=1 -> read_data = write_data (forwarding, same cycle).
  - Else -> stored value.
- Scoreboard (busy bits, reg 1..N_REGS-1), updated on rising clk:
  - reg_write to reg r clears busy[r].
  - reserve_en to reg r sets busy[r].
  - Same r, same cycle: busy[r] = 1 (the new reservation follows the retiring write).
  - Reserve of reg 0 or out-of-range addresses ignored.
  - Reserve of an already-busy register: remains 1 (no counting of outstanding writes).
- read_busy[i] = busy[addr_i] AND NOT (reg_write=1 AND write_register == addr_i).
  - A same-cycle write that forwards the data also releases the stall.
  - read_busy is always 0 for reg 0 and out-of-range addresses.
- busy_count: registered population count of busy bits. Updated in the same edge as the busy bits; never exceeds N_REGS-1.
- Multiple read ports may address the same register; each receives identical data and busy.
- Reset mid-operation: all state clears immediately regardless of clk; pending reservations are lost.
- No X propagation: unused address codes resolve to 0 on every output.

Test Plan:
- Reset, then read ports 0/1 at addrs 5/31 -> read_data 0, read_busy 00, busy_count 0.
- Write 0xDEADBEEF to r7, next cycle read r7 on both ports -> both 0xDEADBEEF. Write 0x1234 to r0 -> r0 still reads 0.
- Same-cycle forward: r9 holds 0x1; drive reg_write r9=0xA5A5A5A5 with port0=r9 -> port0 shows 0xA5A5A5A5 before the clock edge, then the stored value matches after it.
- Scoreboard:
  - reserve r3 -> busy_count 1, port1=r3 gives read_busy[1]=1.
  - Later write r3=0x77 in the same cycle as the read -> read_busy[1]=0, read_data 0x77.
  - After the edge -> busy_count 0.
- Simultaneous reserve and write of r4 with r4 busy -> after the edge busy[r4]=1, busy_count unchanged, new data stored.
- N_REGS=16, N_READ=4 build:
  - Write/reserve r20 -> ignored, reads 0, busy 0.
  - Assert reset low mid-sequence with 3 regs busy and nonzero data -> all read_data 0, busy_count 0 asynchronously.
